// File: rtl/turn_timer_pkg.sv
// ---------------------------------------------------------------------------
// turn_timer_pkg : shared types and BCD MM:SS helpers for turn_timer_bcd
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package turn_timer_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } timer_state_t;

  localparam int unsigned DIG_MAX_UNITS = 9;
  localparam int unsigned DIG_MAX_TENS  = 5;

  typedef struct packed {
    bcd_digit_t m2;
    bcd_digit_t m1;
    bcd_digit_t s2;
    bcd_digit_t s1;
  } mmss_t;

  function automatic logic mmss_is_zero(input mmss_t v);
    return (v == '0);
  endfunction

  // Borrow chain s1 -> s2 -> m1 -> m2; 00:00 saturates rather than wrapping.
  function automatic mmss_t mmss_dec(input mmss_t v);
    mmss_t r;
    r = v;
    if (v.s1 != 4'd0) begin
      r.s1 = v.s1 - 4'd1;
    end else begin
      r.s1 = 4'(DIG_MAX_UNITS);
      if (v.s2 != 4'd0) begin
        r.s2 = v.s2 - 4'd1;
      end else begin
        r.s2 = 4'(DIG_MAX_TENS);
        if (v.m1 != 4'd0) begin
          r.m1 = v.m1 - 4'd1;
        end else begin
          r.m1 = 4'(DIG_MAX_UNITS);
          if (v.m2 != 4'd0) r.m2 = v.m2 - 4'd1;
          else              r    = '0;
        end
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler : free-running divider emitting one tick per TICK_CYCLES
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tick_prescaler #(
  parameter int unsigned TICK_CYCLES = 100_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  if (TICK_CYCLES == 0) begin : g_bad_tick
    $error("tick_prescaler: TICK_CYCLES must be at least 1");
  end

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign tick = en && (cnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/turn_timer_bcd.sv
// ---------------------------------------------------------------------------
// turn_timer_bcd : per-turn MM:SS BCD countdown with run/pause/expire control
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module turn_timer_bcd
  import turn_timer_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 100_000_000,
  parameter int unsigned PRESET_M2   = 0,
  parameter int unsigned PRESET_M1   = 0,
  parameter int unsigned PRESET_S2   = 3,
  parameter int unsigned PRESET_S1   = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  output logic [3:0] sec_dig1,
  output logic [3:0] sec_dig2,
  output logic [3:0] min_dig1,
  output logic [3:0] min_dig2,
  output logic       running,
  output logic       expired
);

  if (PRESET_M2 > DIG_MAX_UNITS || PRESET_M1 > DIG_MAX_UNITS ||
      PRESET_S2 > DIG_MAX_TENS  || PRESET_S1 > DIG_MAX_UNITS) begin : g_bad_preset
    $error("turn_timer_bcd: preset digit outside BCD range");
  end

  localparam mmss_t PRESET = {4'(PRESET_M2), 4'(PRESET_M1),
                              4'(PRESET_S2), 4'(PRESET_S1)};

  timer_state_t state_q, state_d;
  mmss_t        digits_q, digits_d;
  logic         running_q, running_d;
  logic         expired_q, expired_d;
  logic         run_en;
  logic         tick;
  mmss_t        digits_dec;

  assign run_en     = (state_q == RUN);
  assign digits_dec = mmss_dec(digits_q);

  tick_prescaler #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_prescaler (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (run_en),
    .clr    (start | clear),
    .tick   (tick)
  );

  // A tick that lands on the same cycle as pause is still honoured before pausing.
  always_comb begin
    state_d   = state_q;
    digits_d  = digits_q;
    expired_d = 1'b0;
    if (clear) begin
      state_d  = IDLE;
      digits_d = PRESET;
    end else if (start) begin
      digits_d = PRESET;
      if (mmss_is_zero(PRESET)) begin
        state_d   = EXPIRED;
        expired_d = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (tick) begin
            digits_d = digits_dec;
            if (mmss_is_zero(digits_dec)) begin
              state_d   = EXPIRED;
              expired_d = 1'b1;
            end else if (pause) begin
              state_d = PAUSE;
            end
          end else if (pause) begin
            state_d = PAUSE;
          end
        end
        PAUSE: begin
          if (pause) state_d = RUN;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      digits_q  <= PRESET;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      digits_q  <= digits_d;
      running_q <= running_d;
      expired_q <= expired_d;
    end
  end

  assign sec_dig1 = digits_q.s1;
  assign sec_dig2 = digits_q.s2;
  assign min_dig1 = digits_q.m1;
  assign min_dig2 = digits_q.m2;
  assign running  = running_q;
  assign expired  = expired_q;

endmodule

`default_nettype wire
